// File: rtl/phy_utx_fifo.sv
// phy_utx_fifo: FIFO-buffered UART transmitter, configurable width/parity/stop bits
module phy_utx_fifo #(
  parameter int DW      = 8,
  parameter int BIT_CYC = 434,
  parameter int STOP    = 1,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_vld,
  output logic          tx_rdy,
  input  logic [1:0]    par_mode,
  output logic          uart_tx,
  output logic          tx_busy,
  output logic [AW:0]   fifo_lvl
);
  localparam int CW = $clog2(STOP * BIT_CYC);
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP * BIT_CYC - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t state, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bit_idx, bit_d;
  logic [DW-1:0] shreg;
  logic par_en, par_bit, push, pop, empty, last, shift;
  assign fifo_lvl = wr_ptr - rd_ptr;
  assign empty    = wr_ptr == rd_ptr;
  assign tx_rdy   = !(wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = tx_vld & tx_rdy;
  assign tx_busy  = state != S_IDLE || !empty;
  // stop phase is timed as one long interval so the counter needs STOP*BIT_CYC range
  assign last     = cnt == (state == S_STOP ? STOP_END : BIT_END);
  always_comb begin
    state_d = state;
    cnt_d   = last ? '0 : cnt + 1'b1;
    bit_d   = bit_idx;
    pop     = 1'b0;
    shift   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d   = '0;
        pop     = !empty;
        state_d = empty ? S_IDLE : S_START;
      end
      S_START: if (last) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (last) begin
        shift = 1'b1;
        bit_d = bit_idx + 1'b1;
        if (bit_idx == LAST_BIT) state_d = par_en ? S_PAR : S_STOP;
      end
      S_PAR: if (last) state_d = S_STOP;
      S_STOP: if (last) begin
        pop     = !empty;
        state_d = empty ? S_IDLE : S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk_sys)
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  // word and parity setting are captured at pop; uart_tx lags the state by one flop
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr  <= rd_ptr + {{AW{1'b0}}, pop};
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      if (pop) begin
        shreg   <= mem[rd_ptr[AW-1:0]];
        par_en  <= par_mode[0] ^ par_mode[1];
        par_bit <= par_mode[1] ^ (^mem[rd_ptr[AW-1:0]]);
      end else if (shift) shreg <= shreg >> 1;
      uart_tx <= state == S_START ? 1'b0 :
                 state == S_DATA  ? shreg[0] :
                 state == S_PAR   ? par_bit : 1'b1;
    end
endmodule
